stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_stack_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of an external LIFO stack; every output is registered.
// Build option: define STACK_ARB_RR_EN for round-robin arbitration of simultaneous requests.
module stack_arbiter #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [1:0]    op0,
   input  logic [1:0]    op1,
   input  logic [W-1:0]  wdata0,
   input  logic [W-1:0]  wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [W-1:0]  rdata,
   output logic          err,
   output logic          stk_push,
   output logic          stk_pop,
   output logic          stk_tos,
   output logic [W-1:0]  stk_din,
   input  logic [W-1:0]  stk_dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   localparam logic [1:0]    OP_PUSH = 2'b00;
   localparam logic [1:0]    OP_POP  = 2'b01;
   localparam logic [1:0]    OP_PEEK = 2'b10;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic [1:0]    op_q, op_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
   logic          push_q, push_d, pop_q, pop_d, tos_q, tos_d;
   logic [W-1:0]  rdata_q, rdata_d, din_q, din_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q;
   logic          pick;
   logic [1:0]    op_sel;
   logic [W-1:0]  wdata_sel;
   logic          reject;

`ifdef STACK_ARB_RR_EN
   // prio_q names the requester that wins the next tie.
   logic prio_q, prio_d;
   assign pick = (req0 && req1) ? prio_q : req1;
`else
   assign pick = ~req0;
`endif

   assign op_sel    = pick ? op1 : op0;
   assign wdata_sel = pick ? wdata1 : wdata0;

   always_comb begin
      reject = 1'b1;
      case (op_sel)
         OP_PUSH:         reject = (count_q == CNT_MAX);
         OP_POP, OP_PEEK: reject = (count_q == '0);
         default:         reject = 1'b1;
      endcase
   end

   // Outputs are computed for the state being entered, so they appear with that state.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      count_d = count_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      push_d  = 1'b0;
      pop_d   = 1'b0;
      tos_d   = 1'b0;
      din_d   = '0;
`ifdef STACK_ARB_RR_EN
      prio_d  = prio_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d = pick;
               op_d  = op_sel;
`ifdef STACK_ARB_RR_EN
               prio_d = ~pick;
`endif
               if (reject) begin
                  state_d = RESP;
                  ack0_d  = ~pick;
                  ack1_d  = pick;
                  err_d   = 1'b1;
               end else if (op_sel == OP_PUSH) begin
                  state_d = ISSUE;
                  push_d  = 1'b1;
                  din_d   = wdata_sel;
                  count_d = count_q + CW'(1);
               end else begin
                  state_d = ISSUE;
                  tos_d   = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (op_q == OP_PUSH) begin
               state_d = RESP;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
            end else begin
               state_d = CAPT;
               if (op_q == OP_POP) begin
                  pop_d   = 1'b1;
                  count_d = count_q - CW'(1);
               end
            end
         end
         CAPT: begin
            // stk_dout now shows the top sampled by the earlier stk_tos
            state_d = RESP;
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            rdata_d = stk_dout;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         op_q    <= 2'b00;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
         tos_q   <= 1'b0;
         din_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
`ifdef STACK_ARB_RR_EN
         prio_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         push_q  <= push_d;
         pop_q   <= pop_d;
         tos_q   <= tos_d;
         din_q   <= din_d;
         count_q <= count_d;
         full_q  <= (count_d == CNT_MAX);
         empty_q <= (count_d == '0);
`ifdef STACK_ARB_RR_EN
         prio_q  <= prio_d;
`endif
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign stk_push = push_q;
   assign stk_pop  = pop_q;
   assign stk_tos  = tos_q;
   assign stk_din  = din_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: transaction-level stack model with a per-cycle output schedule,
// directed literal checks and two randomized requesters. Honours STACK_ARB_RR_EN like the DUT.
`timescale 1ns/1ps
module tb_stack_arbiter;
   localparam int W     = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, RSVD = 2'b11;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [1:0]    op0 = 2'b00, op1 = 2'b00;
   logic [W-1:0]  wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, err, stk_push, stk_pop, stk_tos, full, empty;
   logic [W-1:0]  rdata, stk_din;
   logic [W-1:0]  stk_dout = '0;
   logic [CW-1:0] count;

   int n_vec = 0;
   int n_err = 0;

   stack_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
      .stk_din(stk_din), .stk_dout(stk_dout),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Stack the DUT talks to: top appears on stk_dout the cycle after stk_tos.
   logic [W-1:0] env_q[$];
   always @(posedge clk) begin
      if (!rst) begin
         env_q.delete();
         stk_dout <= '0;
      end else begin
         if (stk_tos) stk_dout <= (env_q.size() > 0) ? env_q[$] : '0;
         if (stk_push && env_q.size() < DEPTH) env_q.push_back(stk_din);
         if (stk_pop && env_q.size() > 0) void'(env_q.pop_back());
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: expected outputs per cycle ----------------
   typedef struct {
      bit           ack0, ack1, err, push, pop, tos;
      logic [W-1:0] rdata, din;
      int           dc;
   } exp_t;
   exp_t         ring[8];
   logic [W-1:0] mstk[$];
   int           ecnt = 0, free_edge = 0, exp_count = 0, last_gnt = 1;

   task automatic sched_ack(input int c, input int g, input bit e, input logic [W-1:0] r);
      ring[c % 8].ack0  = (g == 0);
      ring[c % 8].ack1  = (g == 1);
      ring[c % 8].err   = e;
      ring[c % 8].rdata = r;
   endtask

   initial begin : model
      exp_t         blank, x;
      int           g;
      logic [1:0]   o;
      logic [W-1:0] d;
      bit           ok;
      blank = '{default: '0};
      for (int i = 0; i < 8; i++) ring[i] = blank;
      forever begin
         @(posedge clk);
         ecnt++;
         if (!rst) begin
            for (int i = 0; i < 8; i++) ring[i] = blank;
            mstk.delete();
            exp_count = 0;
            last_gnt  = 1;
            free_edge = ecnt + 1;
         end else if (ecnt >= free_edge && (req0 || req1)) begin
`ifdef STACK_ARB_RR_EN
            g = (req0 && req1) ? ((last_gnt == 0) ? 1 : 0) : (req1 ? 1 : 0);
`else
            g = req0 ? 0 : 1;
`endif
            last_gnt = g;
            o = (g == 1) ? op1 : op0;
            d = (g == 1) ? wdata1 : wdata0;
            if (o == PUSH && mstk.size() < DEPTH) begin
               mstk.push_back(d);
               ring[ecnt % 8].push = 1'b1;
               ring[ecnt % 8].din  = d;
               ring[ecnt % 8].dc   = 1;
               sched_ack(ecnt + 1, g, 1'b0, '0);
               free_edge = ecnt + 3;
            end else if ((o == POP || o == PEEK) && mstk.size() > 0) begin
               d = mstk[$];
               ring[ecnt % 8].tos = 1'b1;
               if (o == POP) begin
                  void'(mstk.pop_back());
                  ring[(ecnt + 1) % 8].pop = 1'b1;
                  ring[(ecnt + 1) % 8].dc  = -1;
               end
               sched_ack(ecnt + 2, g, 1'b0, d);
               free_edge = ecnt + 4;
            end else begin
               sched_ack(ecnt, g, 1'b1, '0);
               free_edge = ecnt + 2;
            end
         end
         @(negedge clk);
         x = ring[ecnt % 8];
         ring[ecnt % 8] = blank;
         exp_count += x.dc;
         ok = (ack0 === x.ack0) && (ack1 === x.ack1) && (stk_push === x.push) &&
              (stk_pop === x.pop) && (stk_tos === x.tos) && (count === CW'(exp_count)) &&
              (full === (exp_count == DEPTH)) && (empty === (exp_count == 0)) &&
              (!(x.ack0 || x.ack1) || (err === x.err && rdata === x.rdata)) &&
              (!x.push || stk_din === x.din);
         n_vec++;
         if (!ok) begin
            n_err++;
            $display("FAIL cycle %0d: ack=%b%b err=%b push=%b pop=%b tos=%b rdata=%h din=%h cnt=%0d full=%b empty=%b, required ack=%b%b err=%b push=%b pop=%b tos=%b rdata=%h din=%h cnt=%0d",
                     ecnt, ack0, ack1, err, stk_push, stk_pop, stk_tos, rdata, stk_din, count, full, empty,
                     x.ack0, x.ack1, x.err, x.push, x.pop, x.tos, x.rdata, x.din, exp_count);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called one step after a rising edge while the DUT is idle.
   task automatic xact(input int r, input logic [1:0] o, input logic [W-1:0] d,
                       output int lat, output logic [W-1:0] rd, output logic er,
                       output logic [CW-1:0] cnt);
      logic a;
      lat = -1; rd = '0; er = 1'b0; cnt = '0;
      if (r == 0) begin req0 = 1'b1; op0 = o; wdata0 = d; end
      else        begin req1 = 1'b1; op1 = o; wdata1 = d; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a = (r == 0) ? ack0 : ack1;
         if (a) begin lat = i; rd = rdata; er = err; cnt = count; break; end
      end
      @(posedge clk); #1;
      if (r == 0) req0 = 1'b0; else req1 = 1'b0;
      if (lat < 0) chk("ack_timeout", 32'(lat), 0);
      $display("xact req%0d op=%b wdata=%h -> lat=%0d rdata=%h err=%b count=%0d", r, o, d, lat, rd, er, cnt);
   endtask

   int grant_log[$];
   task automatic contend(input int n);
      bit a0, a1;
      int guard;
      guard = 0;
      req0 = 1'b1; op0 = POP;
      req1 = 1'b1; op1 = PUSH; wdata1 = 8'hA5;
      while ((req0 || req1) && guard < 100) begin
         @(negedge clk);
         a0 = ack0; a1 = ack1;
         if (a0) grant_log.push_back(0);
         if (a1) grant_log.push_back(1);
         @(posedge clk); #1;
         if (a0) req0 = (grant_log.size() < n);
         if (a1) req1 = (grant_log.size() < n);
         guard++;
      end
      if (req0 || req1) begin
         chk("contend_timeout", {req0, req1}, 0);
         req0 = 1'b0; req1 = 1'b0;
      end
      $display("contend: %0d grants observed", grant_log.size());
   endtask

   task automatic rand_req(input int r, input int n);
      for (int t = 0; t < n; t++) begin
         int           gap, k, lat;
         logic [1:0]   o;
         logic [W-1:0] d;
         logic         a;
         gap = $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
         k = $urandom_range(0, 9);
         o = (k < 4) ? PUSH : (k < 7) ? POP : (k < 9) ? PEEK : RSVD;
         d = W'($urandom);
         if (r == 0) begin req0 = 1'b1; op0 = o; wdata0 = d; end
         else        begin req1 = 1'b1; op1 = o; wdata1 = d; end
         lat = -1;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = (r == 0) ? ack0 : ack1;
            if (a) begin lat = i; break; end
         end
         if (lat < 0) chk("rand_ack_timeout", 32'(lat), 0);
         $display("rand req%0d op=%b wdata=%h -> wait=%0d rdata=%h err=%b count=%0d", r, o, d, lat, rdata, err, count);
         @(posedge clk); #1;
         if (r == 0) req0 = 1'b0; else req1 = 1'b0;
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int            lat;
      logic [W-1:0]  rd;
      logic          er;
      logic [CW-1:0] cnt;
      bit            found;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {ack0, ack1, err, stk_push, stk_pop, stk_tos, full, empty, rdata, count},
          {8'b0000_0001, 8'h00, 4'h0});
      @(posedge clk); #1;
      rst = 1'b1;

      xact(0, PUSH, 8'h3C, lat, rd, er, cnt);
      chk("push1_lat", 32'(lat), 2); chk("push1_err", er, 0); chk("push1_cnt", cnt, 1);
      chk("push1_rdata", rd, 0); chk("model_cnt_after_push", 32'(exp_count), 1);
      xact(0, PUSH, 8'h30, lat, rd, er, cnt);
      chk("push2_lat", 32'(lat), 2); chk("push2_cnt", cnt, 2);
      xact(1, POP, 8'h00, lat, rd, er, cnt);
      chk("pop_lat", 32'(lat), 3); chk("pop_rdata", rd, 8'h30); chk("pop_cnt", cnt, 1); chk("pop_err", er, 0);
      xact(0, PEEK, 8'h00, lat, rd, er, cnt);
      chk("peek_lat", 32'(lat), 3); chk("peek_rdata", rd, 8'h3C); chk("peek_cnt", cnt, 1);
      xact(1, POP, 8'h00, lat, rd, er, cnt);
      chk("pop_last_rdata", rd, 8'h3C); chk("pop_last_cnt", cnt, 0);
      xact(0, POP, 8'h00, lat, rd, er, cnt);
      chk("pop_empty_lat", 32'(lat), 1); chk("pop_empty_err", er, 1); chk("pop_empty_rdata", rd, 0);
      xact(1, PEEK, 8'h00, lat, rd, er, cnt);
      chk("peek_empty_lat", 32'(lat), 1); chk("peek_empty_err", er, 1);
      xact(0, RSVD, 8'h55, lat, rd, er, cnt);
      chk("rsvd_lat", 32'(lat), 1); chk("rsvd_err", er, 1); chk("rsvd_cnt", cnt, 0);

      for (int i = 0; i <= DEPTH; i++) begin
         xact(i % 2, PUSH, W'(8'h10 + i), lat, rd, er, cnt);
         if (i < DEPTH) begin
            chk("fill_lat", 32'(lat), 2); chk("fill_cnt", cnt, 32'(i + 1));
         end else begin
            chk("overflow_lat", 32'(lat), 1); chk("overflow_err", er, 1);
            chk("overflow_cnt", cnt, DEPTH); chk("overflow_full", full, 1);
         end
      end
      xact(1, PEEK, 8'h00, lat, rd, er, cnt);
      chk("peek_full_rdata", rd, 8'h17);

      contend(6);
      for (int i = 0; i < 6; i++) begin
`ifdef STACK_ARB_RR_EN
         chk("rr_grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));
`else
         chk("fixed_grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 0);
`endif
      end

      // Reset lands on the edge that would have entered CAPT of a POP.
      req1 = 1'b1; op1 = POP;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stk_tos) begin found = 1'b1; break; end
      end
      chk("abort_tos_seen", found, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; req1 = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {ack0, ack1, err, stk_push, stk_pop, stk_tos, full, empty, rdata, count},
          {8'b0000_0001, 8'h00, 4'h0});
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_late_ack_pop", {ack0, ack1, stk_pop}, 0);
      end
      $display("abort: reset during POP completed");

      @(posedge clk); #1;
      fork
         rand_req(0, 120);
         rand_req(1, 120);
      join

      repeat (6) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
